// File: rtl/fifo_wr_arbiter_pkg.sv
// fifo_arb_pkg
// Shared types and width helpers for the FIFO write-port arbiter and its
// round-robin picker. No ports; imported by rr_pick and fifo_wr_arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int unsigned N_REQ_DEF = 4;
  localparam int unsigned BURST_DEF = 8;
  localparam int unsigned IDX_W_DEF = $clog2(N_REQ_DEF);
  localparam int unsigned CNT_W_DEF = $clog2(BURST_DEF) + 1;

  // Burst counter width for a given maximum burst length.
  function automatic int cnt_width(input int burst);
    return $clog2(burst) + 1;
  endfunction

  // (base + k) mod n, valid for base < n and k <= n.
  function automatic int rr_offset(input int base, input int k, input int n);
    int s;
    s = base + k;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick
// Combinational round-robin priority encoder. Searches upward from
// i_last+1 with wrap-around and reports the first set request bit.
// Ports:
//   i_req    [N_REQ-1:0]  request vector
//   i_last   [IDX_W-1:0]  index of the previous winner
//   o_winner [IDX_W-1:0]  chosen index (0 when o_any is low)
//   o_any                 at least one request is set
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_last,
  output logic [IDX_W-1:0] o_winner,
  output logic             o_any
);

  // Walk from the farthest candidate to the nearest so the nearest set bit
  // is the final assignment.
  always_comb begin
    o_winner = '0;
    o_any    = 1'b0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (i_req[rr_offset(int'(i_last), k, N_REQ)]) begin
        o_winner = IDX_W'(rr_offset(int'(i_last), k, N_REQ));
        o_any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Shares one FIFO write port among N_REQ producers with round-robin
// arbitration and a bounded burst per grant. Every grant passes through
// IDLE, giving one bubble cycle between owners.
// Ports:
//   clk, rst              clock, async active-high reset
//   req_valid/req_data    per-requester word valid and packed data
//   req_ready             per-requester accept (owner only, when not full)
//   fifo_full             FIFO full flag
//   fifo_wr_en/fifo_din   FIFO write strobe and data
//   grant/grant_id        one-hot owner / binary current-or-last owner
//   busy                  high while a grant is held
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int N_REQ      = 4,
  parameter int BURST      = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            req_ready,
  input  logic                        fifo_full,
  output logic                        fifo_wr_en,
  output logic [DATA_WIDTH-1:0]       fifo_din,
  output logic [N_REQ-1:0]            grant,
  output logic [$clog2(N_REQ)-1:0]    grant_id,
  output logic                        busy
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = cnt_width(BURST);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST - 1);

  arb_state_t       r_state;
  logic [N_REQ-1:0] r_grant;
  logic [IDX_W-1:0] r_grant_id;
  logic [IDX_W-1:0] r_last_owner;
  logic             r_busy;
  logic [CNT_W-1:0] r_burst_cnt;

  logic [IDX_W-1:0] w_winner;
  logic             w_any;
  logic             w_in_grant;
  logic             w_owner_valid;
  logic             w_xfer;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .i_req    (req_valid),
    .i_last   (r_last_owner),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  assign w_in_grant    = (r_state == GRANT);
  assign w_owner_valid = req_valid[r_grant_id];
  assign w_xfer        = w_in_grant && w_owner_valid && !fifo_full;

  // Outputs are gated by state so reset forces them low asynchronously.
  assign req_ready  = (w_in_grant && !fifo_full) ? r_grant : '0;
  assign fifo_wr_en = w_xfer;
  assign fifo_din   = w_in_grant ? req_data[int'(r_grant_id)*DATA_WIDTH +: DATA_WIDTH]
                                 : '0;
  assign grant      = r_grant;
  assign grant_id   = r_grant_id;
  assign busy       = r_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_grant      <= '0;
      r_grant_id   <= '0;
      r_last_owner <= IDX_W'(N_REQ - 1);
      r_busy       <= 1'b0;
      r_burst_cnt  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state      <= GRANT;
            r_grant      <= N_REQ'(1) << w_winner;
            r_grant_id   <= w_winner;
            r_last_owner <= w_winner;
            r_busy       <= 1'b1;
            r_burst_cnt  <= '0;
          end
        end
        GRANT: begin
          // A gap in owner valid or the final beat of a burst both release.
          if (!w_owner_valid || (w_xfer && r_burst_cnt == LAST_BEAT)) begin
            r_state     <= IDLE;
            r_grant     <= '0;
            r_busy      <= 1'b0;
            r_burst_cnt <= '0;
          end else if (w_xfer) begin
            r_burst_cnt <= r_burst_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_grant <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

  localparam int DW    = 16;
  localparam int N     = 4;
  localparam int BURST = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_ready;
  logic            fifo_full = 1'b0;
  logic            fifo_wr_en;
  logic [DW-1:0]   fifo_din;
  logic [N-1:0]    grant;
  logic [1:0]      grant_id;
  logic            busy;

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .N_REQ(N), .BURST(BURST)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_din   (fifo_din),
    .grant      (grant),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] grant;
    logic [1:0]   gid;
    logic         busy;
    logic         wr;
    logic [N-1:0] ready;
  } exp_t;

  exp_t          cq[$];
  logic [DW-1:0] dq[$];
  logic          wr_hist[$];
  int            gs[$];
  logic          prev_busy = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: owner -1 means no grant held.
  int m_owner, m_cnt, m_last, m_gid;
  int rem[N];
  int seq[N];
  int xfers[N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_cnt   = 0;
    m_last  = N - 1;
    m_gid   = 0;
    for (int i = 0; i < N; i++) begin
      rem[i]   = 0;
      xfers[i] = 0;
    end
  endtask

  // Monitor: pops one cycle expectation per clock and one data word per DUT write.
  always @(negedge clk) begin
    if (!rst && cq.size() > 0) begin
      exp_t e;
      e = cq.pop_front();
      chk("grant", grant, e.grant);
      chk("busy", busy, e.busy);
      chk("grant_id", grant_id, e.gid);
      chk("fifo_wr_en", fifo_wr_en, e.wr);
      chk("req_ready", req_ready, e.ready);
      wr_hist.push_back(fifo_wr_en);
      if (busy && !prev_busy) gs.push_back(int'(grant_id));
      prev_busy = busy;
      if (fifo_wr_en) begin
        chk("write_expected", dq.size() != 0, 1);
        if (dq.size() != 0) chk("fifo_din", fifo_din, dq.pop_front());
      end
    end
  end

  task automatic drive(input logic [N-1:0] mask, input logic full);
    logic [N-1:0] v;
    exp_t e;
    int o;
    bit found;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      v[i] = mask[i] && (rem[i] > 0);
      req_data[i*DW +: DW] = {4'(i), 12'(seq[i])};
    end
    req_valid = v;
    fifo_full = full;
    o = m_owner;
    e.busy  = (o >= 0);
    e.grant = e.busy ? (N'(1) << o) : '0;
    e.gid   = 2'(m_gid);
    e.wr    = 1'b0;
    if (e.busy) e.wr = v[o] && !full;
    e.ready = (e.busy && !full) ? e.grant : '0;
    cq.push_back(e);
    if (e.wr) dq.push_back(req_data[o*DW +: DW]);
    if (o < 0) begin
      if (v != '0) begin
        found = 0;
        for (int k = 1; k <= N; k++) begin
          if (!found && v[(m_last + k) % N]) begin
            found   = 1;
            m_owner = (m_last + k) % N;
          end
        end
        m_last = m_owner;
        m_gid  = m_owner;
        m_cnt  = 0;
      end
    end else if (!v[o]) begin
      m_owner = -1;
    end else if (!full) begin
      m_cnt++;
      xfers[o]++;
      rem[o]--;
      seq[o]++;
      if (m_cnt == BURST) m_owner = -1;
    end
  endtask

  task automatic rst_on();
    rst = 1'b1;
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr_en", fifo_wr_en, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_din", fifo_din, 0);
    chk("rst_grant_id", grant_id, 0);
  endtask

  task automatic rst_off();
    @(posedge clk);
    @(posedge clk);
    #1;
    req_valid = '0;
    fifo_full = 1'b0;
    rst = 1'b0;
    cq.delete();
    dq.delete();
    wr_hist.delete();
    gs.delete();
    prev_busy = 1'b0;
    model_reset();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_on();
    rst_off();
  endtask

  task automatic wait_settle();
    @(negedge clk);
    #1;
  endtask

  function automatic int hist_ones();
    int c;
    c = 0;
    foreach (wr_hist[i]) if (wr_hist[i]) c++;
    return c;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] act_pat;
    logic [31:0] exp_pat;
    int guard;

    for (int i = 0; i < N; i++) seq[i] = 0;
    model_reset();
    rst_on();
    rst_off();

    // Idle after reset.
    repeat (5) drive(4'b0000, 1'b0);
    wait_settle();
    chk("idle_writes", hist_ones(), 0);

    // Single requester, 20 words: 8, bubble, 8, bubble, 4.
    do_reset();
    rem[0] = 20;
    repeat (26) drive(4'b0001, 1'b0);
    wait_settle();
    chk("single_hist_len", wr_hist.size(), 26);
    act_pat = '0;
    exp_pat = '0;
    for (int i = 0; i < 26; i++) begin
      if (i < wr_hist.size()) act_pat[i] = wr_hist[i];
      exp_pat[i] = ((i >= 1 && i <= 8) || (i >= 10 && i <= 17) || (i >= 19 && i <= 22));
    end
    chk("single_write_pattern", act_pat, exp_pat);

    // All four requesters continuously valid: grant order 0,1,2,3,0.
    do_reset();
    for (int i = 0; i < N; i++) rem[i] = 16;
    repeat (40) drive(4'b1111, 1'b0);
    wait_settle();
    chk("rr_grants", gs.size() >= 5, 1);
    if (gs.size() >= 5) begin
      chk("rr_order0", gs[0], 0);
      chk("rr_order1", gs[1], 1);
      chk("rr_order2", gs[2], 2);
      chk("rr_order3", gs[3], 3);
      chk("rr_order4", gs[4], 0);
    end

    // Requester 2 stalls on full after its 3rd word.
    do_reset();
    rem[2] = 8;
    guard = 0;
    while (xfers[2] < 3 && guard < 20) begin
      drive(4'b0100, 1'b0);
      guard++;
    end
    chk("stall_reach3", xfers[2], 3);
    repeat (6) drive(4'b0100, 1'b1);
    wait_settle();
    chk("stall_writes_before", hist_ones(), 3);
    guard = 0;
    while (rem[2] > 0 && guard < 20) begin
      drive(4'b0100, 1'b0);
      guard++;
    end
    repeat (2) drive(4'b0100, 1'b0);
    wait_settle();
    chk("stall_total_writes", hist_ones(), 8);
    chk("stall_single_grant", gs.size(), 1);
    if (gs.size() >= 1) chk("stall_owner", gs[0], 2);

    // Requester 1 drops after 3 words; requester 3 goes next, then 1 again.
    do_reset();
    rem[1] = 3;
    rem[3] = 5;
    guard = 0;
    while (rem[1] > 0 && guard < 20) begin
      drive(4'b1010, 1'b0);
      guard++;
    end
    drive(4'b1010, 1'b0);
    rem[1] = 4;
    repeat (20) drive(4'b1010, 1'b0);
    wait_settle();
    chk("drop_grants", gs.size(), 3);
    if (gs.size() >= 3) begin
      chk("drop_first", gs[0], 1);
      chk("drop_second", gs[1], 3);
      chk("drop_third", gs[2], 1);
    end

    // Reset mid-burst on word 4 of requester 0.
    do_reset();
    rem[0] = 10;
    guard = 0;
    while (xfers[0] < 3 && guard < 20) begin
      drive(4'b0001, 1'b0);
      guard++;
    end
    drive(4'b0001, 1'b0);
    #1;
    chk("pre_rst_wr_en", fifo_wr_en, 1);
    rst_on();
    rst_off();
    rem[0] = 4;
    rem[3] = 4;
    repeat (14) drive(4'b1001, 1'b0);
    wait_settle();
    chk("post_rst_grants", gs.size() >= 2, 1);
    if (gs.size() >= 2) begin
      chk("post_rst_first", gs[0], 0);
      chk("post_rst_second", gs[1], 3);
    end

    // Randomised traffic with random full and valid gaps.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if (rem[i] == 0 && $urandom_range(0, 7) == 0) rem[i] = $urandom_range(1, 20);
      drive(4'($urandom), ($urandom_range(0, 4) == 0));
    end
    wait_settle();
    chk("dq_drained", dq.size(), 0);
    chk("cq_drained", cq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
